mcu_run_ctrl: RTL and testbench
===============================

Name: mcu_run_ctrl

Overview:
Run/load sequencer for the 8-bit accumulator MCU and its 32x8 program/data memory.
- Holds the CPU in reset while a host streams a program image into memory.
- Releases the CPU to run, detects halt or runaway execution, and freezes the CPU for inspection.
- Owns the memory-port mux between the loader and the CPU.
- Sits between the MCU core, the memory and the host/debug interface.

Parameters:
ADDR_W, 5, memory address width; image length is 2**ADDR_W bytes.
DATA_W, 8, memory data width.
HALT_OP, 3'b000, opcode (IR[7:5]) treated as halt.
RUN_LIMIT, 1023, maximum RUN cycles before watchdog timeout; counter width is 10 bits.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
load_req  in  1  pulse: start image load (accepted in IDLE/HALT only)
start  in  1  pulse: reset and run CPU (accepted in IDLE/HALT only)
host_valid  in  1  loader byte valid
host_data  in  DATA_W  loader byte
host_ready  out  1  loader byte accepted when valid&ready
cpu_reset  out  1  active-low reset to MCU core
cpu_clk_en  out  1  MCU clock enable
cpu_read  in  1  MCU READ
cpu_write  in  1  MCU WRITE
cpu_addr  in  ADDR_W  MCU memory address
cpu_wdata  in  DATA_W  MCU write data
cpu_ld_ir  in  1  MCU instruction-register load strobe
cpu_op  in  3  MCU opcode IR[7:5]
cpu_rdata  out  DATA_W  read data to MCU
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_we  out  1  memory write enable
mem_re  out  1  memory read enable
mem_rdata  in  DATA_W  memory read data
state_o  out  3  current state encoding
halted  out  1  high in HALT
timeout  out  1  sticky: last run ended by watchdog
run_cycles  out  10  RUN cycle count of the current/last run

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE, cpu_reset=0, cpu_clk_en=0, host_ready=0.
  - mem_we=0, mem_re=0, halted=0, timeout=0, run_cycles=0, load pointer=0.
- States: IDLE=0, LOAD=1, CRST=2, RUN=3, HALT=4.
- IDLE:
  - CPU held in reset.
  - load_req -> LOAD. start -> CRST.
  - Both asserted in the same cycle: load_req wins.
- LOAD:
  - host_ready=1, cpu_reset=0.
  - Each accepted byte: mem_we=1 in the same cycle, mem_addr=pointer, mem_wdata=host_data; pointer increments mod 2**ADDR_W.
  - The accepted byte at pointer=2**ADDR_W-1 ends the load: pointer wraps to 0, next state IDLE.
  - start/load_req are ignored during LOAD. There is no partial-load abort except reset.
- CRST:
  - Exactly one cycle with cpu_reset=0, cpu_clk_en=0.
  - Clears run_cycles and timeout, then goes to RUN.
- RUN:
  - cpu_reset=1, cpu_clk_en=1.
  - Memory port passes the CPU through: mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_we=cpu_write, mem_re=cpu_read.
  - run_cycles increments each cycle, saturating.
  - Halt: cpu_ld_ir was high in the previous cycle and cpu_op==HALT_OP now.
    - Next state HALT; cpu_clk_en drops the cycle halt is detected (combinational off the registered condition).
  - Watchdog: run_cycles==RUN_LIMIT -> timeout=1, next state HALT.
  - Halt and watchdog in the same cycle: timeout=1.
  - start/load_req are ignored in RUN.
- HALT:
  - cpu_reset=1 (CPU state preserved), cpu_clk_en=0, halted=1.
  - mem_we=0. mem_re and mem_addr follow the CPU inputs.
  - start -> CRST. load_req -> LOAD.
- cpu_rdata=mem_rdata, combinational, in all states.
- All outputs are registered except the memory-port mux and cpu_rdata.

Optional Feature:
Macro: MCU_RUN_CTRL_STEP_EN.
- When defined:
  - Adds an input step (pulse).
  - In HALT, step re-enters RUN for one instruction: RUN continues until the next cpu_ld_ir, then returns to HALT.
  - run_cycles keeps accumulating across steps.
  - A step while the opcode is HALT_OP is ignored.
- When undefined:
  - No step port.
  - HALT exits only via start/load_req.

Test Plan:
- Reset mid-LOAD after 10 bytes -> all outputs return to reset values immediately; next load_req restarts writing at address 0.
- load_req, then 32 bytes 0x00..0x1F with host_valid held high -> mem_we on 32 consecutive cycles at addresses 0..31; IDLE after the last byte; pointer 0.
- Throttled load with host_valid toggled 1/0 -> exactly one write per accepted byte; no write while host_valid=0.
- start from IDLE -> one CRST cycle (cpu_reset=0), then RUN with cpu_clk_en=1; CPU read/write visible on the mem port with the same addr/data.
- RUN, drive cpu_ld_ir=1 then cpu_op=000 next cycle at run_cycles=7 -> HALT; halted=1; cpu_clk_en=0; timeout=0; run_cycles holds 7-8.
- RUN with no halt opcode -> HALT at run_cycles=1023, timeout=1; a following start clears timeout and run_cycles.

Source files
------------

// File: rtl/mcu_run_ctrl.sv
// Run/load sequencer for the 8-bit accumulator MCU: image loader, CPU reset/run/halt control, memory-port mux.
// Optional single-step from HALT is compiled in when MCU_RUN_CTRL_STEP_EN is defined.
module mcu_run_ctrl #(
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned DATA_W    = 8,
    parameter logic [2:0]  HALT_OP   = 3'b000,
    parameter int unsigned RUN_LIMIT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    input  logic              start,
`ifdef MCU_RUN_CTRL_STEP_EN
    input  logic              step,
`endif
    input  logic              host_valid,
    input  logic [DATA_W-1:0] host_data,
    output logic              host_ready,
    output logic              cpu_reset,
    output logic              cpu_clk_en,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_ld_ir,
    input  logic [2:0]        cpu_op,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [2:0]        state_o,
    output logic              halted,
    output logic              timeout,
    output logic [9:0]        run_cycles
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_CRST = 3'd2,
        S_RUN  = 3'd3,
        S_HALT = 3'd4
    } state_e;

    localparam logic [9:0] LIMIT = 10'(RUN_LIMIT);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [9:0]        run_q, run_d;
    logic              timeout_q, timeout_d;
    logic              ld_ir_q;
    logic              host_ready_q;
    logic              cpu_reset_q;
    logic              clk_en_q;
    logic              halted_q;
    logic              accept;
    logic              halt_det;
`ifdef MCU_RUN_CTRL_STEP_EN
    logic              step_mode_q, step_mode_d;
`endif

    assign accept   = (state_q == S_LOAD) && host_valid && host_ready_q;
    // ld_ir_q only captures strobes seen while running, so a stale strobe cannot halt a fresh run
    assign halt_det = (state_q == S_RUN) && ld_ir_q && (cpu_op == HALT_OP);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        run_d     = run_q;
        timeout_d = timeout_q;
`ifdef MCU_RUN_CTRL_STEP_EN
        step_mode_d = step_mode_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (load_req) begin
                    state_d = S_LOAD;
                    ptr_d   = '0;
                end else if (start) begin
                    state_d   = S_CRST;
                    run_d     = '0;
                    timeout_d = 1'b0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    ptr_d = ptr_q + 1'b1;
                    if (ptr_q == '1) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_CRST: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                run_d = (run_q == '1) ? run_q : run_q + 10'd1;
                if (run_q == LIMIT) begin
                    timeout_d = 1'b1;
                    state_d   = S_HALT;
                end
                if (halt_det) begin
                    state_d = S_HALT;
                end
`ifdef MCU_RUN_CTRL_STEP_EN
                if (step_mode_q && cpu_ld_ir) begin
                    state_d = S_HALT;
                end
`endif
            end
            S_HALT: begin
                if (load_req) begin
                    state_d = S_LOAD;
                    ptr_d   = '0;
                end else if (start) begin
                    state_d   = S_CRST;
                    run_d     = '0;
                    timeout_d = 1'b0;
`ifdef MCU_RUN_CTRL_STEP_EN
                end else if (step && (cpu_op != HALT_OP)) begin
                    state_d     = S_RUN;
                    step_mode_d = 1'b1;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef MCU_RUN_CTRL_STEP_EN
        if (state_d != S_RUN) begin
            step_mode_d = 1'b0;
        end
`endif
    end

    // Registered outputs are decoded from the next state so they line up with state_o.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            run_q        <= '0;
            timeout_q    <= 1'b0;
            ld_ir_q      <= 1'b0;
            host_ready_q <= 1'b0;
            cpu_reset_q  <= 1'b0;
            clk_en_q     <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            run_q        <= run_d;
            timeout_q    <= timeout_d;
            ld_ir_q      <= (state_q == S_RUN) && cpu_ld_ir;
            host_ready_q <= (state_d == S_LOAD);
            cpu_reset_q  <= (state_d == S_RUN) || (state_d == S_HALT);
            clk_en_q     <= (state_d == S_RUN);
            halted_q     <= (state_d == S_HALT);
        end
    end

`ifdef MCU_RUN_CTRL_STEP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_mode_q <= 1'b0;
        end else begin
            step_mode_q <= step_mode_d;
        end
    end
`endif

    always_comb begin
        mem_addr  = ptr_q;
        mem_wdata = host_data;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        case (state_q)
            S_LOAD: begin
                mem_we = accept;
            end
            S_RUN: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_we    = cpu_write;
                mem_re    = cpu_read;
            end
            S_HALT: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_re    = cpu_read;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    assign host_ready = host_ready_q;
    assign cpu_reset  = cpu_reset_q;
    assign cpu_clk_en = clk_en_q && !halt_det;
    assign halted     = halted_q;
    assign timeout    = timeout_q;
    assign run_cycles = run_q;
    assign state_o    = state_q;
    assign cpu_rdata  = mem_rdata;

endmodule

// File: tb/tb_mcu_run_ctrl.sv
// Self-checking bench for mcu_run_ctrl: memory writes are scoreboarded, control outputs checked per scenario.
module tb_mcu_run_ctrl;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_CRST = 3'd2;
    localparam logic [2:0] ST_RUN  = 3'd3;
    localparam logic [2:0] ST_HALT = 3'd4;

    typedef struct packed {
        logic [4:0] a;
        logic [7:0] d;
    } wr_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load_req = 1'b0;
    logic       start = 1'b0;
    logic       step = 1'b0;
    logic       host_valid = 1'b0;
    logic [7:0] host_data = '0;
    logic       host_ready;
    logic       cpu_reset;
    logic       cpu_clk_en;
    logic       cpu_read = 1'b0;
    logic       cpu_write = 1'b0;
    logic [4:0] cpu_addr = '0;
    logic [7:0] cpu_wdata = '0;
    logic       cpu_ld_ir = 1'b0;
    logic [2:0] cpu_op = 3'b101;
    logic [7:0] cpu_rdata;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic       mem_re;
    logic [7:0] mem_rdata = '0;
    logic [2:0] state_o;
    logic       halted;
    logic       timeout;
    logic [9:0] run_cycles;

    int  tests_run = 0;
    int  fails = 0;
    wr_t exp_q[$];
    wr_t exp_w;

    mcu_run_ctrl #(.ADDR_W(5), .DATA_W(8), .HALT_OP(3'b000), .RUN_LIMIT(1023)) dut (
        .clk(clk), .reset(reset), .load_req(load_req), .start(start),
`ifdef MCU_RUN_CTRL_STEP_EN
        .step(step),
`endif
        .host_valid(host_valid), .host_data(host_data), .host_ready(host_ready),
        .cpu_reset(cpu_reset), .cpu_clk_en(cpu_clk_en),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ld_ir(cpu_ld_ir), .cpu_op(cpu_op),
        .cpu_rdata(cpu_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
        .state_o(state_o), .halted(halted), .timeout(timeout), .run_cycles(run_cycles)
    );

    always #5 clk = ~clk;

    // Every observed memory write must match the oldest expected write.
    always @(negedge clk) begin
        if (reset && mem_we) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got addr=%h data=%h required no write", mem_addr, mem_wdata);
            end else begin
                exp_w = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== {exp_w.a, exp_w.d}) begin
                    fails++;
                    $display("FAIL mem_write: got addr=%h data=%h required addr=%h data=%h",
                             mem_addr, mem_wdata, exp_w.a, exp_w.d);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "bench time limit expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        load_req = 1'b0; start = 1'b0; host_valid = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0;
        cpu_ld_ir = 1'b0; cpu_op = 3'b101; cpu_addr = '0; cpu_wdata = '0;
        tests_run++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL pending_writes: got %0d outstanding required 0", exp_q.size());
        end
        exp_q.delete();
        #1 reset = 1'b0;
        @(posedge clk);
        #3 reset = 1'b1;
        tick();
    endtask

    task automatic do_load(input bit throttle, input bit with_start, input logic [7:0] seed);
        int unsigned n;
        logic [7:0]  d;
        n = 0;
        load_req = 1'b1; start = with_start;
        tick();
        load_req = 1'b0; start = 1'b0;
        tests_run++;
        if ({state_o, host_ready, cpu_reset, cpu_clk_en, halted} !== {ST_LOAD, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL load_entry: got st=%0d rdy=%b rst=%b en=%b hlt=%b required st=1 rdy=1 rst=0 en=0 hlt=0",
                     state_o, host_ready, cpu_reset, cpu_clk_en, halted);
        end
        for (int cyc = 0; cyc < 80 && n < 32; cyc++) begin
            host_valid = !throttle || (cyc % 2 == 0);
            load_req   = (cyc == 3);
            start      = (cyc == 3);
            if (host_valid) begin
                d = throttle ? 8'($urandom) : seed + 8'(n);
                host_data = d;
                exp_q.push_back({5'(n), d});
                n++;
            end else begin
                host_data = 8'hFF;
            end
            tick();
            if (cyc == 3) begin
                tests_run++;
                if (state_o !== ST_LOAD) begin
                    fails++;
                    $display("FAIL load_ignores_cmds: got st=%0d required st=1", state_o);
                end
            end
        end
        host_valid = 1'b0; load_req = 1'b0; start = 1'b0;
        tests_run++;
        if ({state_o, host_ready, mem_addr, mem_we} !== {ST_IDLE, 1'b0, 5'd0, 1'b0}) begin
            fails++;
            $display("FAIL load_done: got st=%0d rdy=%b ptr=%0d we=%b required st=0 rdy=0 ptr=0 we=0",
                     state_o, host_ready, mem_addr, mem_we);
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL load_all_written: got %0d outstanding required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        tests_run++;
        if ({state_o, cpu_reset, cpu_clk_en, host_ready, mem_we, mem_re, halted, timeout, run_cycles, mem_addr} !== 25'd0) begin
            fails++;
            $display("FAIL reset_values: got st=%0d rst=%b en=%b rdy=%b we=%b re=%b hlt=%b to=%b rc=%0d addr=%0d required all 0",
                     state_o, cpu_reset, cpu_clk_en, host_ready, mem_we, mem_re, halted, timeout, run_cycles, mem_addr);
        end
        @(posedge clk);
        #3 reset = 1'b1;
        tick();
        tests_run++;
        if ({state_o, cpu_reset, host_ready} !== {ST_IDLE, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL idle_after_reset: got st=%0d rst=%b rdy=%b required st=0 rst=0 rdy=0",
                     state_o, cpu_reset, host_ready);
        end
    endtask

    task automatic test_reset_mid_load();
        apply_reset();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            host_valid = 1'b1;
            host_data  = 8'hA0 + 8'(i);
            exp_q.push_back({5'(i), 8'hA0 + 8'(i)});
            tick();
        end
        host_data = 8'hEE;
        #1 reset = 1'b0;
        #1;
        tests_run++;
        if ({state_o, cpu_reset, cpu_clk_en, host_ready, mem_we, mem_re, halted, timeout, run_cycles, mem_addr} !== 25'd0) begin
            fails++;
            $display("FAIL reset_mid_load: got st=%0d rst=%b en=%b rdy=%b we=%b re=%b hlt=%b to=%b rc=%0d addr=%0d required all 0",
                     state_o, cpu_reset, cpu_clk_en, host_ready, mem_we, mem_re, halted, timeout, run_cycles, mem_addr);
        end
        host_valid = 1'b0;
        @(posedge clk);
        #3 reset = 1'b1;
        tick();
        do_load(1'b0, 1'b0, 8'h40);
    endtask

    task automatic test_load();
        apply_reset();
        do_load(1'b0, 1'b1, 8'h00);
    endtask

    task automatic test_throttled();
        apply_reset();
        do_load(1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_run_passthrough();
        apply_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        tests_run++;
        if ({state_o, cpu_reset, cpu_clk_en, run_cycles, timeout} !== {ST_CRST, 1'b0, 1'b0, 10'd0, 1'b0}) begin
            fails++;
            $display("FAIL crst_cycle: got st=%0d rst=%b en=%b rc=%0d to=%b required st=2 rst=0 en=0 rc=0 to=0",
                     state_o, cpu_reset, cpu_clk_en, run_cycles, timeout);
        end
        tick();
        tests_run++;
        if ({state_o, cpu_reset, cpu_clk_en, halted, run_cycles} !== {ST_RUN, 1'b1, 1'b1, 1'b0, 10'd0}) begin
            fails++;
            $display("FAIL run_entry: got st=%0d rst=%b en=%b hlt=%b rc=%0d required st=3 rst=1 en=1 hlt=0 rc=0",
                     state_o, cpu_reset, cpu_clk_en, halted, run_cycles);
        end
        cpu_write = 1'b1; cpu_addr = 5'h15; cpu_wdata = 8'hA5; mem_rdata = 8'h3C;
        exp_q.push_back({5'h15, 8'hA5});
        #1;
        tests_run++;
        if ({mem_addr, mem_wdata, mem_re, cpu_rdata} !== {5'h15, 8'hA5, 1'b0, 8'h3C}) begin
            fails++;
            $display("FAIL run_write_path: got addr=%h wd=%h re=%b rd=%h required addr=15 wd=a5 re=0 rd=3c",
                     mem_addr, mem_wdata, mem_re, cpu_rdata);
        end
        tick();
        cpu_write = 1'b0; cpu_read = 1'b1; cpu_addr = 5'h0A; mem_rdata = 8'hC3;
        load_req = 1'b1; start = 1'b1;
        #1;
        tests_run++;
        if ({mem_addr, mem_re, mem_we, cpu_rdata} !== {5'h0A, 1'b1, 1'b0, 8'hC3}) begin
            fails++;
            $display("FAIL run_read_path: got addr=%h re=%b we=%b rd=%h required addr=0a re=1 we=0 rd=c3",
                     mem_addr, mem_re, mem_we, cpu_rdata);
        end
        tick();
        load_req = 1'b0; start = 1'b0; cpu_read = 1'b0;
        tests_run++;
        if ({state_o, run_cycles} !== {ST_RUN, 10'd2}) begin
            fails++;
            $display("FAIL run_ignores_cmds: got st=%0d rc=%0d required st=3 rc=2", state_o, run_cycles);
        end
    endtask

    task automatic test_halt();
        apply_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        repeat (6) tick();
        tests_run++;
        if (run_cycles !== 10'd6) begin
            fails++;
            $display("FAIL halt_pre_count: got rc=%0d required rc=6", run_cycles);
        end
        cpu_ld_ir = 1'b1;
        tick();
        cpu_ld_ir = 1'b0; cpu_op = 3'b000;
        #1;
        tests_run++;
        if ({state_o, cpu_clk_en, run_cycles} !== {ST_RUN, 1'b0, 10'd7}) begin
            fails++;
            $display("FAIL halt_detect_clk: got st=%0d en=%b rc=%0d required st=3 en=0 rc=7",
                     state_o, cpu_clk_en, run_cycles);
        end
        tick();
        tests_run++;
        if ({state_o, halted, cpu_clk_en, cpu_reset, timeout, run_cycles} !== {ST_HALT, 1'b1, 1'b0, 1'b1, 1'b0, 10'd8}) begin
            fails++;
            $display("FAIL halt_state: got st=%0d hlt=%b en=%b rst=%b to=%b rc=%0d required st=4 hlt=1 en=0 rst=1 to=0 rc=8",
                     state_o, halted, cpu_clk_en, cpu_reset, timeout, run_cycles);
        end
        cpu_write = 1'b1; cpu_read = 1'b1; cpu_addr = 5'h07;
        tick();
        tests_run++;
        if ({state_o, run_cycles, mem_we, mem_re, mem_addr} !== {ST_HALT, 10'd8, 1'b0, 1'b1, 5'h07}) begin
            fails++;
            $display("FAIL halt_mem_port: got st=%0d rc=%0d we=%b re=%b addr=%h required st=4 rc=8 we=0 re=1 addr=07",
                     state_o, run_cycles, mem_we, mem_re, mem_addr);
        end
        cpu_write = 1'b0; cpu_read = 1'b0; cpu_op = 3'b101;
        do_load(1'b0, 1'b0, 8'h80);
    endtask

    task automatic test_watchdog();
        apply_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        repeat (1023) tick();
        tests_run++;
        if ({state_o, timeout, run_cycles, cpu_clk_en} !== {ST_RUN, 1'b0, 10'd1023, 1'b1}) begin
            fails++;
            $display("FAIL wdog_limit: got st=%0d to=%b rc=%0d en=%b required st=3 to=0 rc=1023 en=1",
                     state_o, timeout, run_cycles, cpu_clk_en);
        end
        tick();
        tests_run++;
        if ({state_o, halted, timeout, run_cycles, cpu_clk_en} !== {ST_HALT, 1'b1, 1'b1, 10'd1023, 1'b0}) begin
            fails++;
            $display("FAIL wdog_halt: got st=%0d hlt=%b to=%b rc=%0d en=%b required st=4 hlt=1 to=1 rc=1023 en=0",
                     state_o, halted, timeout, run_cycles, cpu_clk_en);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tests_run++;
        if ({state_o, timeout, run_cycles, cpu_reset} !== {ST_CRST, 1'b0, 10'd0, 1'b0}) begin
            fails++;
            $display("FAIL restart_clears: got st=%0d to=%b rc=%0d rst=%b required st=2 to=0 rc=0 rst=0",
                     state_o, timeout, run_cycles, cpu_reset);
        end
        tick();
        repeat (1022) tick();
        cpu_ld_ir = 1'b1;
        tick();
        cpu_ld_ir = 1'b0; cpu_op = 3'b000;
        tick();
        tests_run++;
        if ({state_o, halted, timeout, run_cycles} !== {ST_HALT, 1'b1, 1'b1, 10'd1023}) begin
            fails++;
            $display("FAIL halt_and_wdog: got st=%0d hlt=%b to=%b rc=%0d required st=4 hlt=1 to=1 rc=1023",
                     state_o, halted, timeout, run_cycles);
        end
        cpu_op = 3'b101;
    endtask

    initial begin
        test_reset();
        test_reset_mid_load();
        test_load();
        test_throttled();
        test_run_passthrough();
        test_halt();
        test_watchdog();
        tick();
        tests_run++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL final_writes: got %0d outstanding required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
